mips_if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core inside top.
- Sits directly upstream of decode. Owns the PC, drives the instruction-memory port, and produces the IF/ID pipeline register that decode consumes.
- Supports decode back-pressure through a one-entry skid buffer.
- Supports branch/jump redirect with flush, and wait-stated instruction memory.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/mips_if_stage_skid_buf.sv | 34 +++
 rtl/mips_if_stage.sv | 121 ++++++++++++
 tb/tb_mips_if_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mips_pkg                                                  |
// | Brief    : Shared types and constants for the MIPS pipeline front.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mips_pkg;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] NOP_INSTR_WORD   = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } if_state_t;

  // IF/ID pipeline register, also consumed by decode
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  // One buffered fetch: where it came from and what came back
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } skid_entry_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_if_stage_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : if_skid_buf                                               |
// | Brief    : One-entry pc+instr buffer catching a fetch under stall.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module if_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  skid_entry_t load_entry,
  output logic        full,
  output skid_entry_t entry
);

  // Clear (redirect) wins over load; load wins over drain
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full  <= 1'b0;
      entry <= '0;
    end else if (load) begin
      full  <= 1'b1;
      entry <= load_entry;
    end else if (drain) begin
      full  <= 1'b0;
    end
  end

endmodule : if_skid_buf
`default_nettype wire

// File: rtl/mips_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mips_if_stage                                             |
// | Brief    : Instruction fetch: PC, imem port, IF/ID register, skid    |
// |            buffer for decode back-pressure, redirect with flush.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mips_if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o
);

  if_state_t   state, state_nxt;
  logic [31:0] pc, pc_nxt;
  ifid_t       ifid, ifid_nxt;
  logic        skid_load, skid_drain, skid_clear;
  logic        skid_full;
  skid_entry_t skid_in, skid_q;

  // Redirect targets are word aligned; the low bits are dropped on purpose
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign skid_in = '{pc: pc, instr: imem_rdata_i};

  if_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (skid_clear),
    .load_entry (skid_in),
    .full       (skid_full),
    .entry      (skid_q)
  );

  // State, PC and IF/ID register update
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= PC_RESET;
      ifid  <= '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ifid  <= ifid_nxt;
    end
  end

  // Next-state, next-PC, IF/ID and skid control; redirect overrides all
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ifid_nxt   = ifid;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;
    if (redirect_i) begin
      pc_nxt     = {redirect_pc_i[31:2], 2'b00};
      ifid_nxt   = '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};
      skid_clear = 1'b1;
      state_nxt  = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready_i && !stall_i) begin
            ifid_nxt = '{valid: 1'b1, pc: pc, pc4: pc + 32'd4, instr: imem_rdata_i};
            pc_nxt   = pc + 32'd4;
          end else if (imem_ready_i && stall_i) begin
            // Decode cannot take it: park the word, stop fetching
            skid_load = 1'b1;
            pc_nxt    = pc + 32'd4;
            state_nxt = HOLD;
          end else if (!stall_i) begin
            // Memory wait state: push a bubble into decode
            ifid_nxt.valid = 1'b0;
            ifid_nxt.instr = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ifid_nxt   = '{valid: 1'b1, pc: skid_q.pc, pc4: skid_q.pc + 32'd4,
                           instr: skid_q.instr};
            skid_drain = 1'b1;
            state_nxt  = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  // skid_full is implied by state==HOLD; kept for observability only
  logic unused_skid_full;
  assign unused_skid_full = skid_full;

  assign imem_req_o   = !rst && (state == FETCH);
  assign imem_addr_o  = pc;
  assign ifid_valid_o = ifid.valid;
  assign ifid_pc_o    = ifid.pc;
  assign ifid_pc4_o   = ifid.pc4;
  assign ifid_instr_o = ifid.instr;

endmodule : mips_if_stage
`default_nettype wire

// File: tb/tb_mips_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mips_if_stage                                          |
// | Brief    : Directed self-checking bench for the IF stage.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mips_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, ready;
  logic [31:0] redirect_pc, rdata;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, ifid_pc, ifid_pc4, ifid_instr;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // Memory model: word is the inverted address; garbage when not ready
  always_comb rdata = ready ? ~imem_addr : 32'hDEAD_BEEF;

  mips_if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (rdata),
    .imem_ready_i  (ready),
    .ifid_valid_o  (ifid_valid),
    .ifid_pc_o     (ifid_pc),
    .ifid_pc4_o    (ifid_pc4),
    .ifid_instr_o  (ifid_instr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample and drive 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] p,
                            input logic [31:0] p4, input logic [31:0] ins);
    check_eq({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, v});
    check_eq({tag, ".pc"},    ifid_pc,    p);
    check_eq({tag, ".pc4"},   ifid_pc4,   p4);
    check_eq({tag, ".instr"}, ifid_instr, ins);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; ready = 1'b1; redirect_pc = 32'h0;
    step(); step();
    // Reset state
    check_eq("rst.req",  {31'h0, imem_req}, 32'h0);
    check_eq("rst.addr", imem_addr, 32'h0);
    check_ifid("rst", 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("run.req0",  {31'h0, imem_req}, 32'h1);
    check_eq("run.addr0", imem_addr, 32'h0);

    // Streaming fetch
    step();
    check_eq("run.addr4", imem_addr, 32'h4);
    check_ifid("run.if0", 1'b1, 32'h0, 32'h4, 32'hFFFF_FFFF);
    step();
    check_eq("run.addr8", imem_addr, 32'h8);
    check_ifid("run.if4", 1'b1, 32'h4, 32'h8, 32'hFFFF_FFFB);

    // Stall three cycles while addr 8 is fetched
    stall = 1'b1;
    step();
    check_eq("stl.req",  {31'h0, imem_req}, 32'h0);
    check_eq("stl.addr", imem_addr, 32'hC);
    check_ifid("stl.h1", 1'b1, 32'h4, 32'h8, 32'hFFFF_FFFB);
    step();
    step();
    check_eq("stl.req3", {31'h0, imem_req}, 32'h0);
    check_ifid("stl.h3", 1'b1, 32'h4, 32'h8, 32'hFFFF_FFFB);
    stall = 1'b0;
    step();
    check_ifid("stl.drain", 1'b1, 32'h8, 32'hC, 32'hFFFF_FFF7);
    check_eq("stl.reqC",  {31'h0, imem_req}, 32'h1);
    check_eq("stl.addrC", imem_addr, 32'hC);
    step();
    check_ifid("stl.ifC", 1'b1, 32'hC, 32'h10, 32'hFFFF_FFF3);
    check_eq("stl.addr10", imem_addr, 32'h10);

    // Memory wait states at addr 0x10; pc field of the bubble is untouched
    ready = 1'b0;
    step();
    check_eq("ws.addr1", imem_addr, 32'h10);
    check_ifid("ws.b1", 1'b0, 32'hC, 32'h10, 32'h0);
    step();
    check_eq("ws.addr2", imem_addr, 32'h10);
    check_ifid("ws.b2", 1'b0, 32'hC, 32'h10, 32'h0);
    ready = 1'b1;
    step();
    check_ifid("ws.if10", 1'b1, 32'h10, 32'h14, 32'hFFFF_FFEF);

    // Enter HOLD at 0x14, then redirect (unaligned) while still stalled
    stall = 1'b1;
    step();
    check_eq("rdh.addr", imem_addr, 32'h18);
    redirect = 1'b1; redirect_pc = 32'h0000_0403;
    step();
    redirect = 1'b0; stall = 1'b0;
    check_eq("rdh.pc",  imem_addr, 32'h400);
    check_eq("rdh.req", {31'h0, imem_req}, 32'h1);
    check_ifid("rdh.flush", 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    // Skid was emptied: the next IF/ID entry is 0x400, not the parked 0x14
    check_ifid("rdh.if400", 1'b1, 32'h400, 32'h404, 32'hFFFF_FBFF);

    // Redirect to top of memory; the same-cycle rdata must be discarded
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check_ifid("wrap.flush", 1'b0, 32'h0, 32'h0, 32'h0);
    check_eq("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check_ifid("wrap.if", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h3);
    check_eq("wrap.addr0", imem_addr, 32'h0);

    // Reset while in HOLD
    stall = 1'b1;
    step();
    check_eq("rsth.req", {31'h0, imem_req}, 32'h0);
    rst = 1'b1;
    step();
    check_eq("rsth.req1", {31'h0, imem_req}, 32'h0);
    check_eq("rsth.addr", imem_addr, 32'h0);
    check_ifid("rsth", 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0; stall = 1'b0;
    #1;
    check_eq("rsth.req2", {31'h0, imem_req}, 32'h1);
    step();
    check_ifid("rsth.if0", 1'b1, 32'h0, 32'h4, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mips_if_stage
`default_nettype wire
